mccu_fsm: RTL and testbench

MCCU_FSM -- requirements
Module: mccu_fsm

---
 rtl/mccu_pkg.sv | 81 ++++++++
 rtl/mccu_decode.sv | 64 ++++++
 rtl/mccu_fsm.sv | 126 ++++++++++++
 tb/tb_mccu_fsm.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mccu_pkg.sv
// rtl/mccu_pkg.sv - shared encodings for the multicycle control unit
package mccu_pkg;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EXE = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } st_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  localparam logic [3:0] ALUC_ADDU = 4'b0000;
  localparam logic [3:0] ALUC_SUBU = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0011;
  localparam logic [3:0] ALUC_AND  = 4'b0100;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0110;
  localparam logic [3:0] ALUC_NOR  = 4'b0111;
  localparam logic [3:0] ALUC_LUI  = 4'b1000;
  localparam logic [3:0] ALUC_SLTU = 4'b1010;
  localparam logic [3:0] ALUC_SLT  = 4'b1011;
  localparam logic [3:0] ALUC_SRA  = 4'b1100;
  localparam logic [3:0] ALUC_SRL  = 4'b1101;
  localparam logic [3:0] ALUC_SLL  = 4'b1110;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_RS   = 2'b10;
  localparam logic [1:0] PC_JUMP = 2'b11;

  // One-hot instruction class; exactly one bit is set for any op/func.
  typedef struct packed {
    logic alu;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic nop;
  } icls_t;

endpackage

// File: rtl/mccu_decode.sv
// rtl/mccu_decode.sv - combinational op/func decode into class and static ALU fields
import mccu_pkg::*;

module mccu_decode (
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output icls_t      cls_o,
  output logic [3:0] aluc_o,
  output logic       sext_o,
  output logic       alua_o,
  output logic       alub_o,
  output logic       regrt_o
);

  always_comb begin
    cls_o   = '0;
    aluc_o  = ALUC_ADDU;
    sext_o  = 1'b0;
    alua_o  = 1'b0;
    alub_o  = 1'b0;
    regrt_o = (op_i != OP_RTYPE);
    case (op_i)
      OP_RTYPE: begin
        cls_o.alu = 1'b1;
        case (func_i)
          F_ADD:  aluc_o = ALUC_ADD;
          F_ADDU: aluc_o = ALUC_ADDU;
          F_SUB:  aluc_o = ALUC_SUB;
          F_SUBU: aluc_o = ALUC_SUBU;
          F_AND:  aluc_o = ALUC_AND;
          F_OR:   aluc_o = ALUC_OR;
          F_XOR:  aluc_o = ALUC_XOR;
          F_NOR:  aluc_o = ALUC_NOR;
          F_SLT:  aluc_o = ALUC_SLT;
          F_SLTU: aluc_o = ALUC_SLTU;
          F_SLL:  begin aluc_o = ALUC_SLL; alua_o = 1'b1; end
          F_SRL:  begin aluc_o = ALUC_SRL; alua_o = 1'b1; end
          F_SRA:  begin aluc_o = ALUC_SRA; alua_o = 1'b1; end
          F_SLLV: aluc_o = ALUC_SLL;
          F_SRLV: aluc_o = ALUC_SRL;
          F_SRAV: aluc_o = ALUC_SRA;
          F_JR:   begin cls_o.alu = 1'b0; cls_o.jr = 1'b1; end
          default: begin cls_o.alu = 1'b0; cls_o.nop = 1'b1; end
        endcase
      end
      OP_J:     cls_o.j = 1'b1;
      OP_JAL:   cls_o.jal = 1'b1;
      OP_BEQ:   begin cls_o.beq = 1'b1; aluc_o = ALUC_SUB; sext_o = 1'b1; end
      OP_BNE:   begin cls_o.bne = 1'b1; aluc_o = ALUC_SUB; sext_o = 1'b1; end
      OP_ADDI:  begin cls_o.alu = 1'b1; aluc_o = ALUC_ADD;  sext_o = 1'b1; alub_o = 1'b1; end
      OP_ADDIU: begin cls_o.alu = 1'b1; aluc_o = ALUC_ADDU; sext_o = 1'b1; alub_o = 1'b1; end
      OP_SLTI:  begin cls_o.alu = 1'b1; aluc_o = ALUC_SLT;  sext_o = 1'b1; alub_o = 1'b1; end
      OP_SLTIU: begin cls_o.alu = 1'b1; aluc_o = ALUC_SLTU; alub_o = 1'b1; end
      OP_ANDI:  begin cls_o.alu = 1'b1; aluc_o = ALUC_AND;  alub_o = 1'b1; end
      OP_ORI:   begin cls_o.alu = 1'b1; aluc_o = ALUC_OR;   alub_o = 1'b1; end
      OP_XORI:  begin cls_o.alu = 1'b1; aluc_o = ALUC_XOR;  alub_o = 1'b1; end
      OP_LUI:   begin cls_o.alu = 1'b1; aluc_o = ALUC_LUI;  alub_o = 1'b1; end
      OP_LW:    begin cls_o.lw = 1'b1;  aluc_o = ALUC_ADD;  sext_o = 1'b1; alub_o = 1'b1; end
      OP_SW:    begin cls_o.sw = 1'b1;  aluc_o = ALUC_ADD;  sext_o = 1'b1; alub_o = 1'b1; end
      default:  cls_o.nop = 1'b1;
    endcase
  end

endmodule

// File: rtl/mccu_fsm.sv
// rtl/mccu_fsm.sv - five-state multicycle control unit (IF/ID/EXE/MEM/WB)
import mccu_pkg::*;

module mccu_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       iord,
  output logic       wmem,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pcsource,
  output logic       wreg,
  output logic       m2reg,
  output logic       regrt,
  output logic       jal,
  output logic       sext,
  output logic       alua,
  output logic       alub,
  output logic [3:0] aluc,
  output logic [2:0] state,
  output logic       instr_done
);

  logic [2:0] state_q, state_d;
  icls_t      cls;

  mccu_decode u_decode (
    .op_i    (op),
    .func_i  (func),
    .cls_o   (cls),
    .aluc_o  (aluc),
    .sext_o  (sext),
    .alua_o  (alua),
    .alub_o  (alub),
    .regrt_o (regrt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IF;
    else        state_q <= state_d;
  end

  assign state = state_q;

  // Outputs are gated by rst_n so nothing strobes while reset is held,
  // even though the held state (IF) would otherwise request memory.
  always_comb begin
    state_d    = ST_IF;
    mem_req    = 1'b0;
    iord       = 1'b0;
    wmem       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pcsource   = PC_SEQ;
    wreg       = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = ST_ID;
          end else begin
            state_d = ST_IF;
          end
        end
        ST_ID: begin
          if (cls.j) begin
            pc_we      = 1'b1;
            pcsource   = PC_JUMP;
            instr_done = 1'b1;
          end else if (cls.jal) begin
            pc_we      = 1'b1;
            pcsource   = PC_JUMP;
            wreg       = 1'b1;
            jal        = 1'b1;
            instr_done = 1'b1;
          end else if (cls.jr) begin
            pc_we      = 1'b1;
            pcsource   = PC_RS;
            instr_done = 1'b1;
          end else if (cls.nop) begin
            instr_done = 1'b1;
          end else begin
            state_d = ST_EXE;
          end
        end
        ST_EXE: begin
          if (cls.beq || cls.bne) begin
            pc_we      = (cls.beq & zero) | (cls.bne & ~zero);
            pcsource   = PC_BR;
            instr_done = 1'b1;
          end else if (cls.lw || cls.sw) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          wmem    = cls.sw;
          if (!mem_ready)  state_d = ST_MEM;
          else if (cls.sw) instr_done = 1'b1;
          else             state_d = ST_WB;
        end
        ST_WB: begin
          wreg       = 1'b1;
          m2reg      = cls.lw;
          instr_done = 1'b1;
        end
        default: state_d = ST_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mccu_fsm.sv
// tb/tb_mccu_fsm.sv - directed self-checking bench for mccu_fsm
module tb_mccu_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, func;
  logic       zero, mem_ready;
  logic       mem_req, iord, wmem, ir_we, pc_we;
  logic [1:0] pcsource;
  logic       wreg, m2reg, regrt, jal, sext, alua, alub;
  logic [3:0] aluc;
  logic [2:0] state;
  logic       instr_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mccu_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .wmem(wmem),
    .ir_we(ir_we), .pc_we(pc_we), .pcsource(pcsource), .wreg(wreg),
    .m2reg(m2reg), .regrt(regrt), .jal(jal), .sext(sext), .alua(alua),
    .alub(alub), .aluc(aluc), .state(state), .instr_done(instr_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the falling edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op = 6'h00; func = 6'h21;
    cyc();
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_done", instr_done, 0);

    // addu
    rst_n = 1'b1; #1;
    chk("addu_if_state", state, 0);
    chk("addu_if_mem_req", mem_req, 1);
    chk("addu_if_iord", iord, 0);
    chk("addu_if_ir_we", ir_we, 1);
    chk("addu_if_pc_we", pc_we, 1);
    chk("addu_if_pcsrc", pcsource, 0);
    cyc();
    chk("addu_id_state", state, 1);
    chk("addu_id_wreg", wreg, 0);
    chk("addu_id_done", instr_done, 0);
    cyc();
    chk("addu_exe_state", state, 2);
    chk("addu_exe_aluc", aluc, 4'b0000);
    chk("addu_exe_wreg", wreg, 0);
    cyc();
    chk("addu_wb_state", state, 4);
    chk("addu_wb_wreg", wreg, 1);
    chk("addu_wb_done", instr_done, 1);
    chk("addu_wb_regrt", regrt, 0);
    chk("addu_wb_aluc", aluc, 4'b0000);
    cyc();
    chk("addu_end_state", state, 0);

    // lw with two wait cycles in MEM
    op = 6'h23;
    cyc();
    chk("lw_id_state", state, 1);
    cyc();
    chk("lw_exe_state", state, 2);
    chk("lw_exe_aluc", aluc, 4'b0010);
    chk("lw_exe_sext", sext, 1);
    chk("lw_exe_alub", alub, 1);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin mem_ready = 1'b1; #1; end
      chk("lw_mem_state", state, 3);
      chk("lw_mem_iord", iord, 1);
      chk("lw_mem_wmem", wmem, 0);
      chk("lw_mem_req", mem_req, 1);
      chk("lw_mem_done", instr_done, 0);
    end
    cyc();
    chk("lw_wb_state", state, 4);
    chk("lw_wb_m2reg", m2reg, 1);
    chk("lw_wb_wreg", wreg, 1);
    chk("lw_wb_regrt", regrt, 1);
    chk("lw_wb_done", instr_done, 1);
    cyc();
    chk("lw_end_state", state, 0);

    // beq taken then not taken
    for (int k = 0; k < 2; k++) begin
      op = 6'h04; zero = (k == 0);
      cyc();
      cyc();
      chk("beq_exe_state", state, 2);
      chk("beq_exe_pc_we", pc_we, (k == 0) ? 1 : 0);
      chk("beq_exe_pcsrc", pcsource, 2'b01);
      chk("beq_exe_done", instr_done, 1);
      chk("beq_exe_aluc", aluc, 4'b0011);
      cyc();
      chk("beq_end_state", state, 0);
    end
    zero = 1'b0;

    // jal
    op = 6'h03;
    cyc();
    chk("jal_id_state", state, 1);
    chk("jal_id_pc_we", pc_we, 1);
    chk("jal_id_pcsrc", pcsource, 2'b11);
    chk("jal_id_wreg", wreg, 1);
    chk("jal_id_jal", jal, 1);
    chk("jal_id_done", instr_done, 1);
    cyc();
    chk("jal_end_state", state, 0);

    // jr
    op = 6'h00; func = 6'h08;
    cyc();
    chk("jr_id_pc_we", pc_we, 1);
    chk("jr_id_pcsrc", pcsource, 2'b10);
    chk("jr_id_wreg", wreg, 0);
    cyc();
    chk("jr_end_state", state, 0);

    // sw interrupted by reset while waiting in MEM
    op = 6'h2B;
    cyc();
    cyc();
    mem_ready = 1'b0;
    cyc();
    chk("sw_mem_state", state, 3);
    chk("sw_mem_wmem", wmem, 1);
    chk("sw_mem_iord", iord, 1);
    cyc();
    chk("sw_mem_hold", state, 3);
    rst_n = 1'b0; #1;
    chk("sw_rst_state", state, 0);
    chk("sw_rst_wmem", wmem, 0);
    chk("sw_rst_pc_we", pc_we, 0);
    chk("sw_rst_mem_req", mem_req, 0);
    cyc();
    chk("sw_rst_hold", state, 0);

    // restart with undefined op
    op = 6'h3F; mem_ready = 1'b1; rst_n = 1'b1; #1;
    chk("und_if_ir_we", ir_we, 1);
    cyc();
    chk("und_id_state", state, 1);
    chk("und_id_done", instr_done, 1);
    chk("und_id_pc_we", pc_we, 0);
    chk("und_id_wreg", wreg, 0);
    chk("und_id_wmem", wmem, 0);
    chk("und_id_ir_we", ir_we, 0);
    cyc();
    chk("und_end_state", state, 0);

    // sll drives shamt onto A
    op = 6'h00; func = 6'h00;
    cyc();
    cyc();
    chk("sll_exe_alua", alua, 1);
    chk("sll_exe_aluc", aluc, 4'b1110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
